cook_timer: RTL and testbench

- Countdown cook timer at the far end of the magnetron-control interface.
- Consumes mag_on and clearn from level2_control, and produces timer_done back to it.
- Holds the cook time as four BCD digits (mm:ss), loaded from the keypad while the magnetron is off.
- Decrements once per second while mag_on is high, and drives the display digits plus a one-cycle end-of-cook pulse for the beeper.

---
 rtl/microwave_pkg.sv | 17 +
 rtl/bcd_down_digit.sv | 32 +++
 rtl/cook_timer.sv | 116 +++++++++++
 tb/tb_cook_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared constants and types for the microwave control slice.
// Holds BCD digit width/limits, the default one-second prescaler divide
// and the cook-timer mode encoding used by cook_timer.
package microwave_pkg;

  localparam int BCD_W            = 4;
  localparam int DIGIT_MAX        = 9;
  localparam int SEC_TENS_WRAP    = 5;
  localparam int TICK_DIV_DEFAULT = 100;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,  // count is 00:00
    MODE_SET  = 2'd1,  // count nonzero, magnetron off (keypad editable)
    MODE_RUN  = 2'd2   // count nonzero, magnetron on (counting down)
  } mode_e;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the cook-time down-counter.
// Ports: clk/reset, clr (sync clear), load/load_val (keypad shift-in),
// dec (decrement), wrap_val (value after borrowing from 0), value, borrow_out.
module bcd_down_digit
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  input  logic [BCD_W-1:0] wrap_val,
  output logic [BCD_W-1:0] value,
  output logic             borrow_out
);

  // Borrow propagates to the next digit in the same cycle as the decrement.
  assign borrow_out = dec && (value == '0);

  // Decrement outranks load; the top never asserts both together anyway.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
    end else if (dec) begin
      value <= borrow_out ? wrap_val : value - BCD_W'(1);
    end else if (load) begin
      value <= load_val;
    end
  end

endmodule

// File: rtl/cook_timer.sv
// Countdown cook timer: mm:ss BCD count loaded from the keypad while the
// magnetron is off, decremented once per TICK_DIV cycles while mag_on is high.
// Ports: clk, reset, clearn, mag_on, key_valid/key_digit in;
// min_tens/min_ones/sec_tens/sec_ones display digits, timer_done, done_pulse out.
module cook_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clearn,
  input  logic             mag_on,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             timer_done,
  output logic             done_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Digit index 0 = sec_ones ... 3 = min_tens.
  localparam logic [BCD_W-1:0] WRAP [4] = '{
    BCD_W'(DIGIT_MAX), BCD_W'(SEC_TENS_WRAP), BCD_W'(DIGIT_MAX), BCD_W'(DIGIT_MAX)
  };

  logic [BCD_W-1:0] dig      [4];
  logic [BCD_W-1:0] load_val [4];
  logic             dec      [4];
  logic             borrow   [4];
  logic [PW-1:0]    presc;
  mode_e            mode;
  logic             tick;
  logic             key_accept;
  logic             count_is_one;
  logic             shifted_zero;

  // Mode is a pure decode of the registered count and the live mag_on level,
  // so it can never disagree with the digits it describes.
  always_comb begin
    mode = MODE_IDLE;
    if (!timer_done) begin
      mode = mag_on ? MODE_RUN : MODE_SET;
    end
  end

  assign tick         = (mode == MODE_RUN) && (presc == PW'(TICK_DIV - 1));
  assign key_accept   = !mag_on && key_valid && (key_digit <= BCD_W'(DIGIT_MAX));
  assign count_is_one = (dig[3] == '0) && (dig[2] == '0) && (dig[1] == '0)
                        && (dig[0] == BCD_W'(1));
  // After a key shift the old min_tens falls off; the rest become the new count.
  assign shifted_zero = (dig[2] == '0) && (dig[1] == '0) && (dig[0] == '0)
                        && (key_digit == '0);

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign dec[g]      = tick;
        assign load_val[g] = key_digit;
      end else begin : g_upper
        assign dec[g]      = borrow[g-1];
        assign load_val[g] = dig[g-1];
      end

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .clr        (!clearn),
        .load       (key_accept),
        .load_val   (load_val[g]),
        .dec        (dec[g]),
        .wrap_val   (WRAP[g]),
        .value      (dig[g]),
        .borrow_out (borrow[g])
      );
    end
  endgenerate

  // Prescaler only advances during RUN; any pause drops the partial second.
  always_ff @(posedge clk) begin
    if (reset || !clearn) begin
      presc <= '0;
    end else if (mode == MODE_RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end else begin
      presc <= '0;
    end
  end

  // timer_done tracks the next-state zero condition so it changes on the same
  // edge as the digits rather than one cycle later.
  always_ff @(posedge clk) begin
    if (reset || !clearn) begin
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= tick && count_is_one;
      if (tick) begin
        timer_done <= count_is_one;
      end else if (key_accept) begin
        timer_done <= shifted_zero;
      end
    end
  end

  assign sec_ones = dig[0];
  assign sec_tens = dig[1];
  assign min_ones = dig[2];
  assign min_tens = dig[3];

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer with TICK_DIV=4.
// Each scenario task builds a step plan; expected display/flags are queued
// as a step is driven and popped/compared one edge later.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clearn = 1'b1;
  logic       mag_on = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       rst, clrn, mag, kv;
    logic [3:0] kd;
    bit         chk;
    logic [15:0] dig;
    logic       done, pulse;
  } step_t;

  typedef struct packed {
    logic [15:0] dig;
    logic        done;
    logic        pulse;
  } exp_t;

  step_t plan [$];
  exp_t  exp_q [$];

  cook_timer #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  // Append n identical steps; only the last one carries a check.
  function automatic void add(int n, logic rst, logic clrn, logic mag, logic kv,
                              logic [3:0] kd, bit chk, logic [15:0] dig,
                              logic done, logic pulse);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s.rst = rst; s.clrn = clrn; s.mag = mag; s.kv = kv; s.kd = kd;
      s.chk = chk && (i == n - 1);
      s.dig = dig; s.done = done; s.pulse = pulse;
      plan.push_back(s);
    end
  endfunction

  function automatic void key(logic [3:0] d, logic [15:0] dig, logic done);
    add(1, 0, 1, 0, 1, d, 1, dig, done, 0);
  endfunction

  function automatic void clear_step();
    add(1, 0, 0, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
  endfunction

  task automatic drive(step_t s);
    reset = s.rst; clearn = s.clrn; mag_on = s.mag;
    key_valid = s.kv; key_digit = s.kd;
  endtask

  task automatic test_reset();
    exp_t e;
    plan.delete();
    add(2, 1, 1, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL reset step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  task automatic test_key_entry();
    exp_t e;
    plan.delete();
    clear_step();
    key(4'd1, 16'h0001, 0);
    key(4'd3, 16'h0013, 0);
    key(4'd0, 16'h0130, 0);
    key(4'd12, 16'h0130, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0130, 0, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL key_entry step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  task automatic test_countdown();
    exp_t e;
    plan.delete();
    clear_step();
    key(4'd2, 16'h0002, 0);
    add(3, 0, 1, 1, 0, 4'd0, 1, 16'h0002, 0, 0);
    add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0001, 0, 0);
    add(3, 0, 1, 1, 0, 4'd0, 1, 16'h0001, 0, 0);
    add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0000, 1, 1);
    for (int k = 0; k < 8; k++) add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0000, 1, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL countdown step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  task automatic test_borrow();
    exp_t e;
    plan.delete();
    clear_step();
    key(4'd1, 16'h0001, 0); key(4'd0, 16'h0010, 0);
    key(4'd0, 16'h0100, 0); key(4'd0, 16'h1000, 0);
    add(3, 0, 1, 1, 0, 4'd0, 1, 16'h1000, 0, 0);
    add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0959, 0, 0);
    clear_step();
    key(4'd1, 16'h0001, 0); key(4'd0, 16'h0010, 0); key(4'd0, 16'h0100, 0);
    add(4, 0, 1, 1, 0, 4'd0, 1, 16'h0059, 0, 0);
    clear_step();
    key(4'd9, 16'h0009, 0); key(4'd9, 16'h0099, 0);
    add(4, 0, 1, 1, 0, 4'd0, 1, 16'h0098, 0, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0098, 0, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL borrow step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    plan.delete();
    clear_step();
    key(4'd5, 16'h0005, 0);
    add(1, 0, 1, 1, 1, 4'd7, 1, 16'h0005, 0, 0);  // key during run is dropped
    add(2, 0, 1, 1, 0, 4'd0, 1, 16'h0005, 0, 0);
    add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0004, 0, 0);
    add(2, 0, 1, 1, 0, 4'd0, 1, 16'h0004, 0, 0);
    add(10, 0, 1, 0, 0, 4'd0, 1, 16'h0004, 0, 0);
    add(3, 0, 1, 1, 0, 4'd0, 1, 16'h0004, 0, 0);
    add(1, 0, 1, 1, 0, 4'd0, 1, 16'h0003, 0, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0003, 0, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL pause step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  task automatic test_clear_and_reset();
    exp_t e;
    plan.delete();
    clear_step();
    key(4'd1, 16'h0001, 0);
    add(3, 0, 1, 1, 0, 4'd0, 1, 16'h0001, 0, 0);
    add(1, 0, 0, 1, 0, 4'd0, 1, 16'h0000, 1, 0);  // clear wins over the tick
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
    key(4'd5, 16'h0005, 0); key(4'd3, 16'h0053, 0); key(4'd0, 16'h0530, 0);
    add(2, 0, 1, 1, 0, 4'd0, 1, 16'h0530, 0, 0);
    add(1, 1, 1, 1, 0, 4'd0, 1, 16'h0000, 1, 0);
    add(1, 0, 1, 0, 0, 4'd0, 1, 16'h0000, 1, 0);
    foreach (plan[i]) begin
      drive(plan[i]);
      if (plan[i].chk) exp_q.push_back('{plan[i].dig, plan[i].done, plan[i].pulse});
      @(posedge clk); #1;
      if (plan[i].chk) begin
        e = exp_q.pop_front(); n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse} !== {e.dig, e.done, e.pulse}) begin
          n_err++;
          $display("FAIL clear_reset step %0d: got %h%h:%h%h done=%b pulse=%b, want %h done=%b pulse=%b",
                   i, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, e.dig, e.done, e.pulse);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_entry();
    test_countdown();
    test_borrow();
    test_pause();
    test_clear_and_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
